// File: rtl/median_window_gen.sv
// median_window_gen: raster-stream SIZE x SIZE neighbourhood generator with one registered output stage.
// Define WIN_COORD_EN to add win_x/win_y (column/row of the window centre pixel).
module median_window_gen #(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned SIZE       = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             pix_in,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  output logic [SIZE*SIZE*8-1:0] win_out,
  output logic                   win_valid,
  output logic                   win_last,
  input  logic                   win_ready
`ifdef WIN_COORD_EN
  ,
  output logic [15:0]            win_x,
  output logic [15:0]            win_y
`endif
);

  localparam int unsigned CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned WB   = SIZE * SIZE * 8;
  localparam int unsigned HALF = (SIZE - 1) / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(SIZE - 1);

  // lb_q[0] is the oldest buffered line, lb_q[SIZE-2] the line just above the current one
  logic [7:0]    lb_q [SIZE-1][IMG_WIDTH];
  logic [7:0]    sh_q [SIZE][SIZE];
  logic [7:0]    sh_d [SIZE][SIZE];
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [WB-1:0] win_q, win_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic          accept, full;

  assign pix_ready = !valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    col_cur = pix_sof ? '0 : col_q;
    row_cur = pix_sof ? '0 : row_q;
    full    = (row_cur >= ROW_FULL) && (col_cur >= COL_FULL);
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  // New rightmost column comes from the line buffers plus the incoming pixel
  always_comb begin
    for (int unsigned r = 0; r < SIZE; r++) begin
      for (int unsigned c = 0; c + 1 < SIZE; c++) begin
        sh_d[r][c] = sh_q[r][c+1];
      end
    end
    for (int unsigned r = 0; r + 1 < SIZE; r++) begin
      sh_d[r][SIZE-1] = lb_q[r][col_cur];
    end
    sh_d[SIZE-1][SIZE-1] = pix_in;
    win_d = '0;
    for (int unsigned r = 0; r < SIZE; r++) begin
      for (int unsigned c = 0; c < SIZE; c++) begin
        win_d[r*SIZE*8 + c*8 +: 8] = sh_d[r][c];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    if (accept && full) begin
      valid_d = 1'b1;
      last_d  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
    end else if (win_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k + 2 < SIZE; k++) begin
        lb_q[k][col_cur] <= lb_q[k+1][col_cur];
      end
      lb_q[SIZE-2][col_cur] <= pix_in;
      sh_q <= sh_d;
    end
  end

`ifdef WIN_COORD_EN
  logic [15:0] x_q, y_q;
  assign win_x = x_q;
  assign win_y = y_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef WIN_COORD_EN
      x_q     <= '0;
      y_q     <= '0;
`endif
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      if (accept && full) begin
        win_q <= win_d;
`ifdef WIN_COORD_EN
        x_q   <= 16'(col_cur) - 16'(HALF);
        y_q   <= 16'(row_cur) - 16'(HALF);
`endif
      end
    end
  end

  assign win_out   = win_q;
  assign win_valid = valid_q;
  assign win_last  = last_q;

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen (8x6 frame, 5x5 window) against an image-array reference model.
// Build with WIN_COORD_EN defined to also check win_x/win_y.
module tb_median_window_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int S  = 5;
  localparam int WB = S * S * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    pix_in;
  logic          pix_valid, pix_sof, pix_ready;
  logic [WB-1:0] win_out;
  logic          win_valid, win_last, win_ready;
`ifdef WIN_COORD_EN
  logic [15:0]   win_x, win_y;
`endif

  median_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SIZE(S)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .win_out(win_out), .win_valid(win_valid), .win_last(win_last),
    .win_ready(win_ready)
`ifdef WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as a 2D image plus the expected output stage
  logic [7:0]    img [H][W];
  int            mrow = 0, mcol = 0;
  logic          exp_valid = 1'b0, exp_last = 1'b0;
  logic [WB-1:0] exp_win = '0;
  logic [15:0]   exp_x = '0, exp_y = '0;
  int            nwin = 0, nlast = 0;

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i / W) * 16 + (i % W));
  endfunction

  task automatic model_reset();
    mrow = 0; mcol = 0;
    exp_valid = 1'b0; exp_last = 1'b0; exp_win = '0;
    exp_x = '0; exp_y = '0;
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] p, input bit wr, output bit acc);
    bit rdy;
    pix_valid = v; pix_sof = s; pix_in = p; win_ready = wr;
    @(negedge clk);
    rdy = !exp_valid || wr;
    chk("pix_ready", WB'(pix_ready), WB'(rdy));
    if (win_valid && wr) begin
      nwin++;
      if (win_last) nlast++;
    end
    acc = v && rdy;
    if (acc) begin
      if (s) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = p;
      if (mrow >= S - 1 && mcol >= S - 1) begin
        for (int r = 0; r < S; r++)
          for (int c = 0; c < S; c++)
            exp_win[r*S*8 + c*8 +: 8] = img[mrow-S+1+r][mcol-S+1+c];
        exp_valid = 1'b1;
        exp_last  = (mrow == H - 1) && (mcol == W - 1);
        exp_x     = 16'(mcol - 2);
        exp_y     = 16'(mrow - 2);
      end else if (wr) begin
        exp_valid = 1'b0; exp_last = 1'b0;
      end
      mcol++;
      if (mcol == W) begin
        mcol = 0; mrow++;
        if (mrow == H) mrow = 0;
      end
    end else if (wr) begin
      exp_valid = 1'b0; exp_last = 1'b0;
    end
    @(posedge clk); #1;
    chk("win_valid", WB'(win_valid), WB'(exp_valid));
    chk("win_last", WB'(win_last), WB'(exp_last));
    chk("win_out", win_out, exp_win);
`ifdef WIN_COORD_EN
    chk("win_x", WB'(win_x), WB'(exp_x));
    chk("win_y", WB'(win_y), WB'(exp_y));
`endif
  endtask

  task automatic drain();
    bit a;
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
  endtask

  initial begin
    bit a;
    int idx, budget;
    logic [7:0] rp;

    // Reset state
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; win_ready = 1'b1;
    #22;
    chk("rst_win_valid", WB'(win_valid), WB'(0));
    chk("rst_win_last", WB'(win_last), WB'(0));
    chk("rst_win_out", win_out, WB'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_pix_ready", WB'(pix_ready), WB'(1));

    // Test 1/2/6: pattern frame, continuous valid
    nwin = 0; nlast = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, pat(i), 1'b1, a);
      if (i == 36) begin
        chk("t1_first_tl", WB'(win_out[7:0]), WB'(8'h00));
        chk("t1_first_ctr", WB'(win_out[103:96]), WB'(8'h22));
        chk("t1_first_br", WB'(win_out[199:192]), WB'(8'h44));
`ifdef WIN_COORD_EN
        chk("t6_first_x", WB'(win_x), WB'(2));
        chk("t6_first_y", WB'(win_y), WB'(2));
`endif
      end
      if (i == W * H - 1) begin
        chk("t2_last_ctr", WB'(win_out[103:96]), WB'(8'h35));
        chk("t2_last_flag", WB'(win_last), WB'(1));
`ifdef WIN_COORD_EN
        chk("t6_last_x", WB'(win_x), WB'(5));
        chk("t6_last_y", WB'(win_y), WB'(3));
`endif
      end
    end
    drain();
    chk("t1_nwin", WB'(nwin), WB'(8));
    chk("t2_nlast", WB'(nlast), WB'(1));

    // Test 3: stall the first window for 3 cycles
    nwin = 0; nlast = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, pat(i), 1'b1, a);
      if (i == 36) begin
        for (int k = 0; k < 3; k++) begin
          step(1'b1, 1'b0, pat(37), 1'b0, a);
          chk("t3_no_accept", WB'(a), WB'(0));
          chk("t3_hold_ctr", WB'(win_out[103:96]), WB'(8'h22));
        end
      end
    end
    drain();
    chk("t3_nwin", WB'(nwin), WB'(8));
    chk("t3_nlast", WB'(nlast), WB'(1));

    // Test 4: abort after 20 pixels with a fresh sof
    nwin = 0; nlast = 0;
    for (int i = 0; i < 20; i++) step(1'b1, i == 0, pat(i), 1'b1, a);
    chk("t4_partial_nwin", WB'(nwin), WB'(0));
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, pat(i), 1'b1, a);
      if (i == 36) chk("t4_first_ctr", WB'(win_out[103:96]), WB'(8'h22));
    end
    drain();
    chk("t4_nwin", WB'(nwin), WB'(8));

    // Test 5: async reset mid-row 4 while a window is pending
    for (int i = 0; i < 38; i++) step(1'b1, i == 0, pat(i), 1'b1, a);
    chk("t5_pre_valid", WB'(win_valid), WB'(1));
    pix_valid = 1'b0; win_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", WB'(win_valid), WB'(0));
    chk("t5_async_out", win_out, WB'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nwin = 0; nlast = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, pat(i), 1'b1, a);
      if (i == 36) chk("t5_first_ctr", WB'(win_out[103:96]), WB'(8'h22));
    end
    drain();
    chk("t5_nwin", WB'(nwin), WB'(8));
    chk("t5_nlast", WB'(nlast), WB'(1));

    // Randomized frames: random pixels, valid gaps and backpressure
    for (int f = 0; f < 4; f++) begin
      nwin = 0; nlast = 0; idx = 0; budget = 0;
      rp = 8'($urandom);
      while (idx < W * H && budget < 2000) begin
        step(($urandom % 4) != 0, idx == 0, rp, ($urandom % 3) != 0, a);
        if (a) begin
          idx++;
          rp = 8'($urandom);
        end
        budget++;
      end
      if (idx < W * H) chk("rand_timeout", WB'(idx), WB'(W * H));
      budget = 0;
      while (win_valid && budget < 50) begin
        step(1'b0, 1'b0, 8'h00, ($urandom % 2) != 0, a);
        budget++;
      end
      chk("rand_nwin", WB'(nwin), WB'(8));
      chk("rand_nlast", WB'(nlast), WB'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
